// File: rtl/nts_rx_pkg.sv
// Shared constants, parser state encoding and byte helpers for the NTS receive buffer.
package nts_rx_pkg;

  localparam logic [2:0] WS_1B = 3'd0;
  localparam logic [2:0] WS_2B = 3'd1;
  localparam logic [2:0] WS_4B = 3'd2;
  localparam logic [2:0] WS_8B = 3'd3;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam int          ETH_HDR_LEN    = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } parser_state_e;

  // Byte count of a wordsize code; unsupported codes give 0 (read returns zero).
  function automatic logic [3:0] ws_bytes(input logic [2:0] ws);
    case (ws)
      WS_1B:   return 4'd1;
      WS_2B:   return 4'd2;
      WS_4B:   return 4'd4;
      WS_8B:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Picks nbytes starting at byte 'off' of a big-endian 16-byte window, right-aligned.
  function automatic logic [63:0] extract_bytes(input logic [127:0] cat,
                                                input logic [2:0]   off,
                                                input logic [3:0]   nbytes);
    logic [127:0] sh;
    sh = cat << {off, 3'b000};
    if (nbytes == 4'd0) return 64'h0;
    return sh[127:64] >> (7'd64 - {nbytes, 3'b000});
  endfunction

endpackage

// File: rtl/nts_parser_ctrl.sv
// Header snoop and UDP destination-port fetch FSM; drives the buffer's byte access port.
module nts_parser_ctrl
  import nts_rx_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_clear,
  input  logic                  i_process_initial,
  input  logic [31:0]           i_word_lo,
  input  logic [7:0]            i_last_word_data_valid,
  input  logic                  i_ap_wait,
  input  logic                  i_ap_rd_dv,
  input  logic [15:0]           i_ap_rd_data,
  output logic                  o_ap_rd_en,
  output logic [ADDR_WIDTH+2:0] o_ap_addr,
  output logic [2:0]            o_ap_wordsize,
  output parser_state_e         o_state,
  output logic                  o_detect_ipv4,
  output logic                  o_detect_ipv4_bad,
  output logic [15:0]           o_ethernet_protocol,
  output logic [3:0]            o_ip_version,
  output logic [ADDR_WIDTH+3:0] o_packet_length,
  output logic [15:0]           o_udp_dst_port
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int LEN_W = ADDR_WIDTH + 4;
  localparam int BA_W  = ADDR_WIDTH + 3;

  parser_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] widx_q, widx_d;
  logic             strb_q, strb_d;
  logic [15:0]      eth_q, eth_d;
  logic [3:0]       ver_q, ver_d;
  logic [3:0]       ihl_q, ihl_d;
  logic [7:0]       proto_q, proto_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ipv4_q, ipv4_d;
  logic             bad_q, bad_d;
  logic [15:0]      port_q, port_d;
  logic [6:0]       off_q, off_d;
  logic             issued_q, issued_d;

  logic             hdr_ipv4;
  logic             is_udp;
  logic [6:0]       udp_off;
  logic [LEN_W-1:0] len_calc;
  logic             udp_fits;

  assign hdr_ipv4 = (eth_q == ETHERTYPE_IPV4) && (ver_q == 4'd4) && (ihl_q >= 4'd5);
  assign is_udp   = (proto_q == IP_PROTO_UDP);
  assign udp_off  = 7'(ETH_HDR_LEN) + {1'b0, ihl_q, 2'b00} + 7'd2;
  assign len_calc = {cnt_q - CNT_W'(1), 3'b000} + LEN_W'(count_ones(i_last_word_data_valid));
  // Both port bytes must lie inside the packet.
  assign udp_fits = (LEN_W'(udp_off) + LEN_W'(1)) < len_calc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    strb_d   = strb_q;
    eth_d    = eth_q;
    ver_d    = ver_q;
    ihl_d    = ihl_q;
    proto_d  = proto_q;
    len_d    = len_q;
    ipv4_d   = ipv4_q;
    bad_d    = bad_q;
    port_d   = port_q;
    off_d    = off_q;
    issued_d = issued_q;
    if (i_clear) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      widx_d   = '0;
      strb_d   = 1'b0;
      eth_d    = '0;
      ver_d    = '0;
      ihl_d    = '0;
      proto_d  = '0;
      len_d    = '0;
      ipv4_d   = 1'b0;
      bad_d    = 1'b0;
      port_d   = '0;
      off_d    = '0;
      issued_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_process_initial) begin
            state_d = ST_SNOOP;
            cnt_d   = CNT_W'(1);
            widx_d  = '0;
            strb_d  = 1'b1;
            eth_d   = '0;
            ver_d   = '0;
            ihl_d   = '0;
            proto_d = '0;
          end
        end
        ST_SNOOP: begin
          strb_d = i_process_initial;
          if (i_process_initial) begin
            cnt_d  = cnt_q + CNT_W'(1);
            widx_d = cnt_q;
          end
          // Data of the word strobed last cycle is on the bus now.
          if (strb_q && widx_q == CNT_W'(1)) begin
            eth_d = i_word_lo[31:16];
            ver_d = i_word_lo[15:12];
            ihl_d = i_word_lo[11:8];
          end
          if (strb_q && widx_q == CNT_W'(2)) proto_d = i_word_lo[7:0];
          if (!i_process_initial && !strb_q) begin
            len_d  = len_calc;
            ipv4_d = hdr_ipv4;
            bad_d  = ((eth_q == ETHERTYPE_IPV4) && !hdr_ipv4) ||
                     (hdr_ipv4 && is_udp && !udp_fits);
            if (hdr_ipv4 && is_udp && udp_fits) begin
              state_d  = ST_FETCH;
              off_d    = udp_off;
              issued_d = 1'b0;
            end else begin
              state_d = ST_DONE;
              port_d  = '0;
            end
          end
        end
        ST_FETCH: begin
          if (!issued_q && !i_ap_wait) issued_d = 1'b1;
          if (issued_q && i_ap_rd_dv) begin
            port_d  = i_ap_rd_data;
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      widx_q   <= '0;
      strb_q   <= 1'b0;
      eth_q    <= '0;
      ver_q    <= '0;
      ihl_q    <= '0;
      proto_q  <= '0;
      len_q    <= '0;
      ipv4_q   <= 1'b0;
      bad_q    <= 1'b0;
      port_q   <= '0;
      off_q    <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      widx_q   <= widx_d;
      strb_q   <= strb_d;
      eth_q    <= eth_d;
      ver_q    <= ver_d;
      ihl_q    <= ihl_d;
      proto_q  <= proto_d;
      len_q    <= len_d;
      ipv4_q   <= ipv4_d;
      bad_q    <= bad_d;
      port_q   <= port_d;
      off_q    <= off_d;
      issued_q <= issued_d;
    end
  end

  assign o_ap_rd_en          = (state_q == ST_FETCH) && !issued_q;
  assign o_ap_addr           = BA_W'(off_q);
  assign o_ap_wordsize       = WS_2B;
  assign o_state             = state_q;
  assign o_detect_ipv4       = ipv4_q;
  assign o_detect_ipv4_bad   = bad_q;
  assign o_ethernet_protocol = eth_q;
  assign o_ip_version        = ver_q;
  assign o_packet_length     = len_q;
  assign o_udp_dst_port      = port_q;

endmodule

// File: rtl/nts_rx_buffer_parser.sv
// Receive packet RAM with byte-addressed access port and header parser.
// Define NTS_RX_EXT_ACCESS_EN to expose the access port externally once parsing is done.
module nts_rx_buffer_parser
  import nts_rx_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_clear,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_dispatch_fifo_rd_en,
  input  logic [63:0]           i_dispatch_fifo_rd_data,
  input  logic                  i_process_initial,
  input  logic [7:0]            i_last_word_data_valid,
`ifdef NTS_RX_EXT_ACCESS_EN
  input  logic                  i_ext_rd_en,
  input  logic [ADDR_WIDTH+2:0] i_ext_addr,
  input  logic [2:0]            i_ext_wordsize,
  output logic                  o_ext_wait,
  output logic                  o_ext_rd_dv,
  output logic [63:0]           o_ext_rd_data,
`endif
  output logic                  o_detect_ipv4,
  output logic                  o_detect_ipv4_bad,
  output logic [15:0]           o_ethernet_protocol,
  output logic [3:0]            o_ip_version,
  output logic [ADDR_WIDTH+3:0] o_packet_length,
  output logic [15:0]           o_udp_dst_port,
  output logic                  o_parser_done
);

  localparam int BA_W  = ADDR_WIDTH + 3;
  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef NTS_RX_EXT_ACCESS_EN
  localparam int AP_DW = 64;
`else
  localparam int AP_DW = 16;
`endif

  localparam logic [1:0] AP_IDLE   = 2'd0;
  localparam logic [1:0] AP_FIRST  = 2'd1;
  localparam logic [1:0] AP_SECOND = 2'd2;

  logic [63:0]           mem [0:DEPTH-1];
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [63:0]           ram_rdata_q;

  logic                  ap_rd_en;
  logic [BA_W-1:0]       ap_addr;
  logic [2:0]            ap_ws;
  logic                  ap_wait;
  logic [1:0]            ap_phase_q, ap_phase_d;
  logic [2:0]            ap_off_q, ap_off_d;
  logic [2:0]            ap_ws_q, ap_ws_d;
  logic                  ap_span_q, ap_span_d;
  logic [ADDR_WIDTH-1:0] ap_word1_q, ap_word1_d;
  logic [63:0]           ap_w0_q, ap_w0_d;
  logic [AP_DW-1:0]      ap_data_q, ap_data_d;
  logic                  ap_dv_q, ap_dv_d;

  logic                  par_rd_en;
  logic [BA_W-1:0]       par_addr;
  logic [2:0]            par_ws;
  parser_state_e         parser_state;
  logic                  parser_done;

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q   <= i_dispatch_fifo_rd_en;
      wr_addr_q <= i_addr;
    end
  end

  // Read-first: a read of the word being written returns its previous contents.
  always_ff @(posedge i_clk) begin
    if (wr_en_q) mem[wr_addr_q] <= i_dispatch_fifo_rd_data;
    ram_rdata_q <= mem[ram_raddr];
  end

  assign ap_wait   = (ap_phase_q != AP_IDLE);
  assign ram_raddr = (ap_phase_q == AP_FIRST) ? ap_word1_q : ap_addr[BA_W-1:3];

  always_comb begin
    ap_phase_d = ap_phase_q;
    ap_off_d   = ap_off_q;
    ap_ws_d    = ap_ws_q;
    ap_span_d  = ap_span_q;
    ap_word1_d = ap_word1_q;
    ap_w0_d    = ap_w0_q;
    ap_data_d  = ap_data_q;
    ap_dv_d    = 1'b0;
    if (i_clear) begin
      ap_phase_d = AP_IDLE;
    end else begin
      case (ap_phase_q)
        AP_IDLE: begin
          if (ap_rd_en) begin
            ap_phase_d = AP_FIRST;
            ap_off_d   = ap_addr[2:0];
            ap_ws_d    = ap_ws;
            ap_span_d  = ({2'b00, ap_addr[2:0]} + {1'b0, ws_bytes(ap_ws)}) > 5'd8;
            ap_word1_d = ap_addr[BA_W-1:3] + ADDR_WIDTH'(1);
          end
        end
        AP_FIRST: begin
          if (ap_span_q) begin
            ap_w0_d    = ram_rdata_q;
            ap_phase_d = AP_SECOND;
          end else begin
            ap_data_d  = AP_DW'(extract_bytes({ram_rdata_q, 64'h0}, ap_off_q, ws_bytes(ap_ws_q)));
            ap_dv_d    = 1'b1;
            ap_phase_d = AP_IDLE;
          end
        end
        AP_SECOND: begin
          ap_data_d  = AP_DW'(extract_bytes({ap_w0_q, ram_rdata_q}, ap_off_q, ws_bytes(ap_ws_q)));
          ap_dv_d    = 1'b1;
          ap_phase_d = AP_IDLE;
        end
        default: ap_phase_d = AP_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      ap_phase_q <= AP_IDLE;
      ap_off_q   <= '0;
      ap_ws_q    <= '0;
      ap_span_q  <= 1'b0;
      ap_word1_q <= '0;
      ap_w0_q    <= '0;
      ap_data_q  <= '0;
      ap_dv_q    <= 1'b0;
    end else begin
      ap_phase_q <= ap_phase_d;
      ap_off_q   <= ap_off_d;
      ap_ws_q    <= ap_ws_d;
      ap_span_q  <= ap_span_d;
      ap_word1_q <= ap_word1_d;
      ap_w0_q    <= ap_w0_d;
      ap_data_q  <= ap_data_d;
      ap_dv_q    <= ap_dv_d;
    end
  end

  assign parser_done   = (parser_state == ST_DONE);
  assign o_parser_done = parser_done;

`ifdef NTS_RX_EXT_ACCESS_EN
  // The external requester owns the port only after the parser has finished.
  assign ap_rd_en      = parser_done ? i_ext_rd_en    : par_rd_en;
  assign ap_addr       = parser_done ? i_ext_addr     : par_addr;
  assign ap_ws         = parser_done ? i_ext_wordsize : par_ws;
  assign o_ext_wait    = parser_done ? ap_wait : 1'b1;
  assign o_ext_rd_dv   = parser_done & ap_dv_q;
  assign o_ext_rd_data = ap_data_q;
`else
  assign ap_rd_en = par_rd_en;
  assign ap_addr  = par_addr;
  assign ap_ws    = par_ws;
`endif

  nts_parser_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_parser (
    .i_clk                 (i_clk),
    .i_areset              (i_areset),
    .i_clear               (i_clear),
    .i_process_initial     (i_process_initial),
    .i_word_lo             (i_dispatch_fifo_rd_data[31:0]),
    .i_last_word_data_valid(i_last_word_data_valid),
    .i_ap_wait             (ap_wait),
    .i_ap_rd_dv            (ap_dv_q),
    .i_ap_rd_data          (ap_data_q[15:0]),
    .o_ap_rd_en            (par_rd_en),
    .o_ap_addr             (par_addr),
    .o_ap_wordsize         (par_ws),
    .o_state               (parser_state),
    .o_detect_ipv4         (o_detect_ipv4),
    .o_detect_ipv4_bad     (o_detect_ipv4_bad),
    .o_ethernet_protocol   (o_ethernet_protocol),
    .o_ip_version          (o_ip_version),
    .o_packet_length       (o_packet_length),
    .o_udp_dst_port        (o_udp_dst_port)
  );

endmodule

// File: tb/tb_nts_rx_buffer_parser.sv
// Directed bench for nts_rx_buffer_parser; covers the external port when NTS_RX_EXT_ACCESS_EN is defined.
module tb_nts_rx_buffer_parser;
  import nts_rx_pkg::*;

  localparam int AW = 10;

  logic          clk;
  logic          i_areset;
  logic          i_clear;
  logic [AW-1:0] i_addr;
  logic          i_dispatch_fifo_rd_en;
  logic [63:0]   i_dispatch_fifo_rd_data;
  logic          i_process_initial;
  logic [7:0]    i_last_word_data_valid;
  logic          o_detect_ipv4;
  logic          o_detect_ipv4_bad;
  logic [15:0]   o_ethernet_protocol;
  logic [3:0]    o_ip_version;
  logic [AW+3:0] o_packet_length;
  logic [15:0]   o_udp_dst_port;
  logic          o_parser_done;
`ifdef NTS_RX_EXT_ACCESS_EN
  logic          i_ext_rd_en;
  logic [AW+2:0] i_ext_addr;
  logic [2:0]    i_ext_wordsize;
  logic          o_ext_wait;
  logic          o_ext_rd_dv;
  logic [63:0]   o_ext_rd_data;
`endif

  int         n_vec;
  int         n_miss;
  logic [7:0] pkt [0:63];

  nts_rx_buffer_parser #(.ADDR_WIDTH(AW)) dut (
    .i_clk                  (clk),
    .i_areset               (i_areset),
    .i_clear                (i_clear),
    .i_addr                 (i_addr),
    .i_dispatch_fifo_rd_en  (i_dispatch_fifo_rd_en),
    .i_dispatch_fifo_rd_data(i_dispatch_fifo_rd_data),
    .i_process_initial      (i_process_initial),
    .i_last_word_data_valid (i_last_word_data_valid),
`ifdef NTS_RX_EXT_ACCESS_EN
    .i_ext_rd_en            (i_ext_rd_en),
    .i_ext_addr             (i_ext_addr),
    .i_ext_wordsize         (i_ext_wordsize),
    .o_ext_wait             (o_ext_wait),
    .o_ext_rd_dv            (o_ext_rd_dv),
    .o_ext_rd_data          (o_ext_rd_data),
`endif
    .o_detect_ipv4          (o_detect_ipv4),
    .o_detect_ipv4_bad      (o_detect_ipv4_bad),
    .o_ethernet_protocol    (o_ethernet_protocol),
    .o_ip_version           (o_ip_version),
    .o_packet_length        (o_packet_length),
    .o_udp_dst_port         (o_udp_dst_port),
    .o_parser_done          (o_parser_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic init_pkt();
    for (int i = 0; i < 64; i++) pkt[i] = i[7:0];
  endtask

  task automatic make_pkt(input logic [15:0] eth, input logic [7:0] verihl,
                          input logic [7:0] proto, input int port_off, input logic [15:0] port);
    init_pkt();
    pkt[12]         = eth[15:8];
    pkt[13]         = eth[7:0];
    pkt[14]         = verihl;
    pkt[23]         = proto;
    pkt[port_off]   = port[15:8];
    pkt[port_off+1] = port[7:0];
  endtask

  function automatic logic [63:0] word_of(input int w);
    logic [63:0] r;
    r = 64'h0;
    for (int b = 0; b < 8; b++) r = {r[55:0], pkt[w*8+b]};
    return r;
  endfunction

  // Strobe nw words; FIFO data follows each strobe by one cycle.
  task automatic send_frame(input int nw, input logic [7:0] lwdv);
    i_last_word_data_valid = lwdv;
    for (int k = 0; k <= nw; k++) begin
      @(negedge clk);
      i_dispatch_fifo_rd_en   = (k < nw);
      i_process_initial       = (k < nw);
      i_addr                  = k[AW-1:0];
      i_dispatch_fifo_rd_data = (k > 0) ? word_of(k-1) : 64'h0;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!o_parser_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic ipv4, input logic bad, input logic [15:0] eth,
                              input logic [3:0] ver, input int len, input logic [15:0] port);
    check_vec({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_vec({tag, "_done"}, 64'(o_parser_done), 64'd1);
    check_vec({tag, "_ipv4"}, 64'(o_detect_ipv4), 64'(ipv4));
    check_vec({tag, "_bad"}, 64'(o_detect_ipv4_bad), 64'(bad));
    check_vec({tag, "_eth"}, 64'(o_ethernet_protocol), 64'(eth));
    check_vec({tag, "_ver"}, 64'(o_ip_version), 64'(ver));
    check_vec({tag, "_len"}, 64'(o_packet_length), 64'(len));
    check_vec({tag, "_port"}, 64'(o_udp_dst_port), 64'(port));
  endtask

`ifdef NTS_RX_EXT_ACCESS_EN
  task automatic ext_read(input string tag, input logic [AW+2:0] addr, input logic [2:0] ws,
                          input int exp_lat, input logic [63:0] exp_data);
    int cyc;
    @(negedge clk);
    check_vec({tag, "_wait_before"}, 64'(o_ext_wait), 64'd0);
    i_ext_addr     = addr;
    i_ext_wordsize = ws;
    i_ext_rd_en    = 1'b1;
    @(negedge clk);
    i_ext_rd_en = 1'b0;
    cyc = 1;
    check_vec({tag, "_wait_after"}, 64'(o_ext_wait), 64'd1);
    while (!o_ext_rd_dv && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_vec({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check_vec({tag, "_data"}, o_ext_rd_data, exp_data);
  endtask
`endif

  initial begin
    int lat;
    n_vec  = 0;
    n_miss = 0;
    i_areset = 1'b0;
    i_clear = 1'b0;
    i_addr = '0;
    i_dispatch_fifo_rd_en = 1'b0;
    i_dispatch_fifo_rd_data = 64'h0;
    i_process_initial = 1'b0;
    i_last_word_data_valid = 8'h00;
`ifdef NTS_RX_EXT_ACCESS_EN
    i_ext_rd_en = 1'b0;
    i_ext_addr = '0;
    i_ext_wordsize = 3'd0;
`endif
    repeat (2) @(negedge clk);
    check_vec("rst_done", 64'(o_parser_done), 64'd0);
    check_vec("rst_ipv4", 64'(o_detect_ipv4), 64'd0);
    check_vec("rst_bad", 64'(o_detect_ipv4_bad), 64'd0);
    check_vec("rst_eth", 64'(o_ethernet_protocol), 64'd0);
    check_vec("rst_ver", 64'(o_ip_version), 64'd0);
    check_vec("rst_len", 64'(o_packet_length), 64'd0);
    check_vec("rst_port", 64'(o_udp_dst_port), 64'd0);
    i_areset = 1'b1;
    pulse_clear();

    // IPv4/UDP, IHL 5, port at bytes 36-37: fetch path completes 5 cycles after copy.
    make_pkt(16'h0800, 8'h45, 8'd17, 36, 16'h1234);
    send_frame(6, 8'hff);
    wait_done(lat);
    check_result("udp_a", lat, 5, 1'b1, 1'b0, 16'h0800, 4'd4, 48, 16'h1234);

    pulse_clear();
    check_vec("clr_done", 64'(o_parser_done), 64'd0);
    check_vec("clr_len", 64'(o_packet_length), 64'd0);
    check_vec("clr_port", 64'(o_udp_dst_port), 64'd0);

    make_pkt(16'h86dd, 8'h60, 8'd17, 36, 16'h5678);
    send_frame(4, 8'h3f);
    wait_done(lat);
    check_result("ipv6", lat, 2, 1'b0, 1'b0, 16'h86dd, 4'd6, 30, 16'h0000);

    pulse_clear();
    make_pkt(16'h0800, 8'h65, 8'd17, 36, 16'h1234);
    send_frame(6, 8'hff);
    wait_done(lat);
    check_result("ver6", lat, 2, 1'b0, 1'b1, 16'h0800, 4'd6, 48, 16'h0000);

    // Length 37: second port byte at 37 is outside the packet.
    pulse_clear();
    make_pkt(16'h0800, 8'h45, 8'd17, 36, 16'h1234);
    send_frame(5, 8'h1f);
    wait_done(lat);
    check_vec("short_latency", 64'(lat), 64'd2);
    check_vec("short_bad", 64'(o_detect_ipv4_bad), 64'd1);
    check_vec("short_len", 64'(o_packet_length), 64'd37);
    check_vec("short_port", 64'(o_udp_dst_port), 64'd0);

    pulse_clear();
    send_frame(5, 8'h3f);
    wait_done(lat);
    check_result("edge38", lat, 5, 1'b1, 1'b0, 16'h0800, 4'd4, 38, 16'h1234);

    // Clear while the port fetch is in flight.
    pulse_clear();
    send_frame(6, 8'hff);
    repeat (3) @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    check_vec("fclr_done", 64'(o_parser_done), 64'd0);
    check_vec("fclr_port", 64'(o_udp_dst_port), 64'd0);
    repeat (4) @(negedge clk);
    check_vec("fclr_done_later", 64'(o_parser_done), 64'd0);
    check_vec("fclr_port_later", 64'(o_udp_dst_port), 64'd0);

    make_pkt(16'h0800, 8'h46, 8'd17, 40, 16'hbeef);
    send_frame(7, 8'hff);
    wait_done(lat);
    check_result("ihl6", lat, 5, 1'b1, 1'b0, 16'h0800, 4'd4, 56, 16'hbeef);

`ifdef NTS_RX_EXT_ACCESS_EN
    pulse_clear();
    check_vec("ext_wait_busy", 64'(o_ext_wait), 64'd1);
    init_pkt();
    send_frame(6, 8'hff);
    wait_done(lat);
    check_vec("ext_frame_done", 64'(o_parser_done), 64'd1);
    ext_read("ext_4b", 13'd6, 3'd2, 3, 64'h06070809);
    ext_read("ext_1b", 13'd9, 3'd0, 2, 64'h09);
    ext_read("ext_8b", 13'd16, 3'd3, 2, 64'h1011121314151617);
`endif

    // Reset in the middle of a copy.
    pulse_clear();
    make_pkt(16'h0800, 8'h45, 8'd17, 36, 16'h1234);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_dispatch_fifo_rd_en   = 1'b1;
      i_process_initial       = 1'b1;
      i_addr                  = k[AW-1:0];
      i_dispatch_fifo_rd_data = (k > 0) ? word_of(k-1) : 64'h0;
    end
    i_areset = 1'b0;
    #1;
    check_vec("mid_rst_eth", 64'(o_ethernet_protocol), 64'd0);
    check_vec("mid_rst_ver", 64'(o_ip_version), 64'd0);
    check_vec("mid_rst_len", 64'(o_packet_length), 64'd0);
    check_vec("mid_rst_done", 64'(o_parser_done), 64'd0);
    i_dispatch_fifo_rd_en = 1'b0;
    i_process_initial     = 1'b0;
    repeat (2) @(negedge clk);
    i_areset = 1'b1;

    send_frame(6, 8'hff);
    wait_done(lat);
    check_result("post_rst", lat, 5, 1'b1, 1'b0, 16'h0800, 4'd4, 48, 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
